// File: rtl/calc_pkg.sv
// Shared types and constants for the pushbutton calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    WAIT    = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  localparam int MAX_OPERAND = 9999;
  localparam int MAX_DIGITS  = 4;

endpackage

// File: rtl/dec_accum.sv
// Decimal operand accumulator: shifts in one digit per strobe up to MAX_DIGITS.
module dec_accum #(
  parameter int OPW        = 14,
  parameter int MAX_DIGITS = 4,
  localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_load,
  input  logic [OPW-1:0] i_load_value,
  input  logic [CW-1:0]  i_load_count,
  input  logic           i_digit_stb,
  input  logic [3:0]     i_digit,
  output logic [OPW-1:0] o_value,
  output logic           o_full
);
  import calc_pkg::*;

  logic [OPW-1:0] r_value;
  logic [CW-1:0]  r_count;
  logic [OPW-1:0] w_next_value;

  assign w_next_value = r_value * OPW'(10) + OPW'(i_digit);
  assign o_full       = (r_count >= CW'(MAX_DIGITS));
  assign o_value      = r_value;

  // Clear beats load beats digit; non-decimal keys never reach the value.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_value <= i_load_value;
      r_count <= i_load_count;
    end else if (i_digit_stb && (i_digit <= 4'd9) && !o_full) begin
      r_value <= w_next_value;
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Operand entry and ALU handshake sequencer for the pushbutton calculator.
module calc_sequencer #(
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS,
  parameter int OPW        = 14,
  parameter int RESW       = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic            digit_valid,
  input  logic [3:0]      digit,
  input  logic            op_valid,
  input  logic [1:0]      op_code,
  input  logic            eq_valid,
  input  logic            clr_valid,
  input  logic            alu_done,
  input  logic [RESW-1:0] alu_result,
  input  logic            alu_err,
  output logic            alu_start,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [1:0]      alu_op,
  output logic [RESW-1:0] disp_value,
  output logic            disp_err,
  output logic [2:0]      state_o
);
  import calc_pkg::*;

  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int TCW = $clog2(TIMEOUT);

  state_t          r_state;
  op_t             r_op;
  logic [RESW-1:0] r_result;
  logic [TCW-1:0]  r_tcount;

  state_t          w_state_next;
  logic            w_clr, w_eq, w_op, w_dig;
  logic            w_a_clear, w_a_load, w_a_digit, w_a_full;
  logic [OPW-1:0]  w_a_load_value, w_a_value;
  logic [CW-1:0]   w_a_load_count;
  logic            w_b_clear, w_b_digit, w_b_full;
  logic [OPW-1:0]  w_b_value;
  logic            w_op_load, w_result_load, w_tcount_clear, w_tcount_inc;

  // Only the highest-priority strobe of a cycle is allowed to act.
  assign w_clr = clr_valid;
  assign w_eq  = eq_valid && !clr_valid;
  assign w_op  = op_valid && !clr_valid && !eq_valid;
  assign w_dig = digit_valid && !clr_valid && !eq_valid && !op_valid;

  dec_accum #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(hz100), .reset(reset), .i_clear(w_a_clear), .i_load(w_a_load),
    .i_load_value(w_a_load_value), .i_load_count(w_a_load_count),
    .i_digit_stb(w_a_digit), .i_digit(digit), .o_value(w_a_value), .o_full(w_a_full)
  );

  dec_accum #(.OPW(OPW), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(hz100), .reset(reset), .i_clear(w_b_clear), .i_load(1'b0),
    .i_load_value('0), .i_load_count('0),
    .i_digit_stb(w_b_digit), .i_digit(digit), .o_value(w_b_value), .o_full(w_b_full)
  );

  always_ff @(posedge hz100) begin
    if (reset) begin
      r_state  <= ENTER_A;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_tcount <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_op_load)     r_op     <= op_t'(op_code);
      if (w_result_load) r_result <= alu_result;
      if (w_tcount_clear)    r_tcount <= '0;
      else if (w_tcount_inc) r_tcount <= r_tcount + TCW'(1);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_a_clear      = 1'b0;
    w_a_load       = 1'b0;
    w_a_load_value = '0;
    w_a_load_count = '0;
    w_a_digit      = 1'b0;
    w_b_clear      = 1'b0;
    w_b_digit      = 1'b0;
    w_op_load      = 1'b0;
    w_result_load  = 1'b0;
    w_tcount_clear = 1'b0;
    w_tcount_inc   = 1'b0;
    if (w_clr) begin
      w_a_clear    = 1'b1;
      w_b_clear    = 1'b1;
      w_state_next = ENTER_A;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_op) begin
            w_op_load    = 1'b1;
            w_b_clear    = 1'b1;
            w_state_next = ENTER_B;
          end else if (w_dig && !w_a_full) begin
            w_a_digit = 1'b1;
          end
        end
        ENTER_B: begin
          if (w_eq)                      w_state_next = EXEC;
          else if (w_op)                 w_op_load = 1'b1;
          else if (w_dig && !w_b_full)   w_b_digit = 1'b1;
        end
        EXEC: begin
          w_tcount_clear = 1'b1;
          w_state_next   = WAIT;
        end
        // A done on the final timeout cycle still counts as a completion.
        WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              w_state_next = ERROR;
            end else begin
              w_result_load = 1'b1;
              w_state_next  = RESULT;
            end
          end else if (r_tcount == TCW'(TIMEOUT - 1)) begin
            w_state_next = ERROR;
          end else begin
            w_tcount_inc = 1'b1;
          end
        end
        // Chaining reuses the result as a full-width A so no more digits append to it.
        RESULT: begin
          if (w_op) begin
            if (r_result <= RESW'(MAX_OPERAND)) begin
              w_a_load       = 1'b1;
              w_a_load_value = r_result[OPW-1:0];
              w_a_load_count = CW'(MAX_DIGITS);
              w_op_load      = 1'b1;
              w_b_clear      = 1'b1;
              w_state_next   = ENTER_B;
            end else begin
              w_state_next = ERROR;
            end
          end else if (w_dig && (digit <= 4'd9)) begin
            w_a_load       = 1'b1;
            w_a_load_value = OPW'(digit);
            w_a_load_count = CW'(1);
            w_state_next   = ENTER_A;
          end
        end
        ERROR:   w_state_next = ERROR;
        default: w_state_next = ENTER_A;
      endcase
    end
  end

  // B is frozen through EXEC/WAIT, so showing it there holds the last displayed value.
  always_comb begin
    disp_value = '0;
    case (r_state)
      ENTER_A:             disp_value = RESW'(w_a_value);
      ENTER_B, EXEC, WAIT: disp_value = RESW'(w_b_value);
      RESULT:              disp_value = r_result;
      default:             disp_value = '0;
    endcase
  end

  assign alu_start = (r_state == EXEC);
  assign alu_a     = w_a_value;
  assign alu_b     = w_b_value;
  assign alu_op    = r_op;
  assign disp_err  = (r_state == ERROR);
  assign state_o   = r_state;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Sequences operand entry and ALU execution for the pushbutton calculator.
- Consumes one-cycle digit, operator, equals and clear strobes from the button front-end, and accumulates decimal operands A and B.
- Issues a single start pulse to the ALU, then waits for done with a timeout.
- Holds the value to display on the seven-segment path: the operand being entered, the result, or an error.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits per operand; further digits are ignored.
- OPW, 14, operand width in bits (9999 < 2^14).
- RESW, 16, ALU result width in bits.
- TIMEOUT, 255, cycles to wait for alu_done before entering ERROR.

Ports:
- hz100  in  1  system clock
- reset  in  1  synchronous, active-high reset
- digit_valid  in  1  one-cycle strobe; a new digit key was pressed
- digit  in  4  digit value 0-9; qualified by digit_valid
- op_valid  in  1  one-cycle strobe; an operator key was pressed
- op_code  in  2  operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- eq_valid  in  1  one-cycle strobe; equals key
- clr_valid  in  1  one-cycle strobe; clear key
- alu_done  in  1  one-cycle strobe; ALU result is valid
- alu_result  in  RESW  ALU result; sampled when alu_done is high
- alu_err  in  1  ALU error (divide by zero or overflow); sampled with alu_done
- alu_start  out  1  one-cycle start pulse to the ALU
- alu_a  out  OPW  operand A; stable from the alu_start cycle until alu_done
- alu_b  out  OPW  operand B; stable from the alu_start cycle until alu_done
- alu_op  out  2  latched operator
- disp_value  out  RESW  value to display
- disp_err  out  1  display shows the error pattern
- state_o  out  3  current state, for debug LEDs

Behaviour:
- Clocking and reset: single clock hz100; reset is synchronous and active-high.
- Reset values: state=ENTER_A. All outputs are 0: alu_start, alu_a, alu_b, alu_op, disp_value, disp_err. Digit count=0 and timeout counter=0.
- Strobe priority within one cycle: clr > eq > op > digit. Only the highest-priority strobe acts; the others are dropped.
- clr_valid in any state (including WAIT): A=B=0, counts=0, disp_err=0, next state ENTER_A. A later alu_done is ignored.
- Accumulation: acc <= acc*10 + digit, computed at OPW width, only while count < MAX_DIGITS, then count++. Digits above 9 are ignored. Leading zeros count as digits.
- Latency: disp_value reflects the active accumulator one cycle after the strobe.
- ENTER_A:
  - digit accumulates into A.
  - op latches alu_op and moves to ENTER_B with B=0, countB=0.
  - eq is ignored.
- ENTER_B:
  - digit accumulates into B.
  - op replaces alu_op; B is unchanged.
  - eq moves to EXEC.
- EXEC: alu_start=1 for exactly one cycle, timeout counter=0, then WAIT.
- WAIT:
  - Counter increments each cycle. All digit, op and eq strobes are ignored.
  - alu_done with alu_err=0 latches alu_result into disp_value, then RESULT.
  - alu_done with alu_err=1, or counter reaching TIMEOUT-1 without done, moves to ERROR with disp_err=1.
  - alu_done arriving on the same cycle as the timeout wins.
- RESULT:
  - digit starts a new A: A=digit, count=1, state ENTER_A.
  - op chains: if result ≤ 9999, A=result[OPW-1:0], countA=MAX_DIGITS, latch op, B=0, state ENTER_B. Otherwise go to ERROR.
  - eq is ignored.
- ERROR: only clr exits; all other strobes are ignored.
- Stray alu_done outside WAIT is ignored.
- SUB results are taken as the unsigned RESW value from the ALU; no sign handling in this block.
- disp_value mapping: ENTER_A shows A, ENTER_B shows B, EXEC/WAIT hold the previous value, RESULT shows the result, ERROR shows 0 with disp_err=1.
- state_o encoding: ENTER_A 0, ENTER_B 1, EXEC 2, WAIT 3, RESULT 4, ERROR 5.

Decomposition:
- Package calc_pkg:
  - state enum (ENTER_A, ENTER_B, EXEC, WAIT, RESULT, ERROR) with the state_o encoding above.
  - op_code enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - constants MAX_OPERAND=9999 and MAX_DIGITS=4.
- One sub-module, dec_accum, instantiated twice (A and B), with inputs:
  - clear
  - load (value, count)
  - digit strobe
- dec_accum outputs value and full.

Test Plan:
- Keys 1,2,3 then ADD, then 4,5, then eq; ALU returns done with 168 three cycles later -> one alu_start pulse with alu_a=123, alu_b=45, alu_op=0; disp_value=168 and state RESULT.
- Digits 9,8,7,6,5 -> A=9876; the 5th digit is ignored; disp_value=9876.
- Digit and clr strobes in the same cycle, in ENTER_B with B=12 -> A=B=0 and state ENTER_A; the digit is dropped.
- eq into WAIT with no alu_done for 255 cycles -> ERROR and disp_err=1; a later alu_done is ignored; clr returns to ENTER_A.
- In RESULT with result=168: MUL, 2, eq -> alu_a=168, alu_b=2, alu_op=2. Separately, with result=12000, pressing an op -> ERROR.
- Reset asserted during WAIT -> next cycle state ENTER_A and all outputs 0; alu_done on the following cycle changes nothing.
